// File: rtl/pb_debounce_multi_pkg.sv
// Shared types for the pushbutton conditioner: per-channel FSM states,
// decoded contact condition and the (nc, no) -> contact decode function.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    CLOSED  = 2'd1,
    TRANSIT = 2'd2,
    INVALID = 2'd3
  } contact_t;

  // Inputs are the synchronized, active-high contact levels.
  function automatic contact_t decode(input logic nc, input logic no);
    contact_t c;
    case ({nc, no})
      2'b10:   c = OPEN;
      2'b01:   c = CLOSED;
      2'b00:   c = TRANSIT;
      default: c = INVALID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pb_debounce_multi_if.sv
// Pin-side and user-side signals of the pushbutton conditioner.
// master drives the raw contacts, slave (the conditioner) drives the results.
interface pb_debounce_multi_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] i_nc;
  logic [N_CH-1:0] i_no;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_repeat;
  logic [N_CH-1:0] o_fault;

  modport master (
    output i_nc, i_no,
    input  o_level, o_press, o_release, o_repeat, o_fault
  );

  modport slave (
    input  i_nc, i_no,
    output o_level, o_press, o_release, o_repeat, o_fault
  );
endinterface

// File: rtl/pb_debounce_multi_channel.sv
// One pushbutton channel: 2-flop synchronizer, break-before-make decode,
// counter debounce FSM, stuck-contact fault detect and optional auto-repeat.
// Auto-repeat is built only when PB_AUTOREPEAT_EN is defined.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_nc,
  input  logic i_no,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_fault
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic nc_s1_q, nc_s2_q, no_s1_q, no_s2_q;
  contact_t contact_s;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [CNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc_s;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic fault_q, fault_d;

  // Synchronize the inverted (active-high) contacts; reset to the OPEN pattern.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nc_s1_q <= 1'b1;
      nc_s2_q <= 1'b1;
      no_s1_q <= 1'b0;
      no_s2_q <= 1'b0;
    end else begin
      nc_s1_q <= ~i_nc;
      nc_s2_q <= nc_s1_q;
      no_s1_q <= ~i_no;
      no_s2_q <= no_s1_q;
    end
  end

  assign contact_s  = decode(nc_s2_q, no_s2_q);
  assign cnt_inc_s  = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign fcnt_inc_s = (fcnt_q == DB_MAX) ? fcnt_q : fcnt_q + CNT_ONE;

  // Debounce FSM next state, counter and registered-output next values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (contact_s == CLOSED) begin
          if (DB_MAX == CNT_ONE) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        case (contact_s)
          CLOSED: begin
            if (cnt_inc_s == DB_MAX) begin
              state_d = PRESSED;
              cnt_d   = CNT_ZERO;
              press_d = 1'b1;
              level_d = 1'b1;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end
          TRANSIT: cnt_d = cnt_q;
          default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        endcase
      end
      PRESSED: begin
        if (contact_s == OPEN) begin
          if (DB_MAX == CNT_ONE) begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      RELEASE_WAIT: begin
        case (contact_s)
          OPEN: begin
            if (cnt_inc_s == DB_MAX) begin
              state_d   = IDLE;
              cnt_d     = CNT_ZERO;
              release_d = 1'b1;
              level_d   = 1'b0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end
          TRANSIT: cnt_d = cnt_q;
          default: begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  // Stuck-contact detect: count consecutive INVALID samples, clear on any other.
  always_comb begin
    if (contact_s == INVALID) begin
      fcnt_d  = fcnt_inc_s;
      fault_d = (fcnt_inc_s == DB_MAX);
    end else begin
      fcnt_d  = CNT_ZERO;
      fault_d = 1'b0;
    end
  end

  // FSM, counters and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      fcnt_q    <= CNT_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      fault_q   <= fault_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_fault   = fault_q;

`ifdef PB_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W  = $clog2(REP_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_RATE  = HOLD_W'(REPEAT_RATE);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_next_s;
  logic armed_q, armed_d;
  logic repeat_q, repeat_d;

  assign hold_next_s = hold_q + HOLD_W'(1);

  // Hold counter runs only while staying in PRESSED; first pulse after the
  // delay, later pulses at the rate. Any exit clears the sequence.
  always_comb begin
    hold_d   = HOLD_W'(0);
    armed_d  = 1'b0;
    repeat_d = 1'b0;
    if ((state_q == PRESSED) && (state_d == PRESSED)) begin
      if (hold_next_s == (armed_q ? HOLD_RATE : HOLD_DELAY)) begin
        hold_d   = HOLD_W'(0);
        armed_d  = 1'b1;
        repeat_d = 1'b1;
      end else begin
        hold_d  = hold_next_s;
        armed_d = armed_q;
      end
    end else begin
      hold_d = HOLD_W'(0);
    end
  end

  // Auto-repeat registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q   <= HOLD_W'(0);
      armed_q  <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      armed_q  <= armed_d;
      repeat_q <= repeat_d;
    end
  end

  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_multi.sv
// N-channel SPDT pushbutton conditioner top: replicates pb_channel per
// button. Optional auto-repeat is enabled with PB_AUTOREPEAT_EN.
module pb_debounce_multi
  import pb_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pb_debounce_multi_if.slave pb
);

  logic [N_CH-1:0] level_s, press_s, release_s, repeat_s, fault_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_nc     (pb.i_nc[g]),
      .i_no     (pb.i_no[g]),
      .o_level  (level_s[g]),
      .o_press  (press_s[g]),
      .o_release(release_s[g]),
      .o_repeat (repeat_s[g]),
      .o_fault  (fault_s[g])
    );
  end

  assign pb.o_level   = level_s;
  assign pb.o_press   = press_s;
  assign pb.o_release = release_s;
  assign pb.o_repeat  = repeat_s;
  assign pb.o_fault   = fault_s;

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed self-checking bench for pb_debounce_multi (N_CH=2, DEBOUNCE=4,
// REPEAT_DELAY=10, REPEAT_RATE=3). Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after a rising edge.
module tb_pb_debounce_multi;

  localparam int N_CH = 2;
  localparam int DB   = 4;

  // Pin patterns {nc_pin, no_pin}, contacts are active-low.
  localparam logic [1:0] PIN_OPEN    = 2'b01;
  localparam logic [1:0] PIN_CLOSED  = 2'b10;
  localparam logic [1:0] PIN_TRANSIT = 2'b11;
  localparam logic [1:0] PIN_INVALID = 2'b00;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pb_debounce_multi_if #(.N_CH(N_CH)) pb ();

  pb_debounce_multi #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .pb   (pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] pins);
    pb.i_nc[ch] = pins[1];
    pb.i_no[ch] = pins[0];
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ch(0, PIN_OPEN);
    set_ch(1, PIN_OPEN);
    wait_ticks(3);
    checks++;
    if ({pb.o_level, pb.o_press, pb.o_release, pb.o_repeat, pb.o_fault} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {pb.o_level, pb.o_press, pb.o_release, pb.o_repeat, pb.o_fault});
    end
    rst = 1'b0;
    wait_ticks(5);
    checks++;
    if ({pb.o_level, pb.o_press, pb.o_release, pb.o_fault} !== 8'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 0", {pb.o_level, pb.o_press, pb.o_release, pb.o_fault});
    end
  endtask

  task automatic test_clean_press();
    set_ch(0, PIN_CLOSED);
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (pb.o_press !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_press n=%0d: press=%b required %b", n, pb.o_press, (n == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (pb.o_level !== ((n >= 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_level n=%0d: level=%b required %b", n, pb.o_level, (n >= 6) ? 2'b01 : 2'b00);
      end
    end
    set_ch(0, PIN_OPEN);
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (pb.o_release !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_release n=%0d: release=%b required %b", n, pb.o_release, (n == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (pb.o_level !== ((n >= 6) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL release_level n=%0d: level=%b required %b", n, pb.o_level, (n >= 6) ? 2'b00 : 2'b01);
      end
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 5; t++) begin
      for (int h = 0; h < 2; h++) begin
        set_ch(0, (h == 0) ? PIN_CLOSED : PIN_OPEN);
        tick();
        checks++;
        if (pb.o_press !== 2'b00 || pb.o_level !== 2'b00) begin
          errors++;
          $display("FAIL bounce_quiet t=%0d: press=%b level=%b required 00 00", t, pb.o_press, pb.o_level);
        end
        tick();
        checks++;
        if (pb.o_press !== 2'b00 || pb.o_level !== 2'b00) begin
          errors++;
          $display("FAIL bounce_quiet t=%0d: press=%b level=%b required 00 00", t, pb.o_press, pb.o_level);
        end
      end
    end
    set_ch(0, PIN_CLOSED);
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (pb.o_press !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL bounce_press n=%0d: press=%b required %b", n, pb.o_press, (n == 6) ? 2'b01 : 2'b00);
      end
    end
    set_ch(0, PIN_OPEN);
    wait_ticks(10);
    checks++;
    if (pb.o_level !== 2'b00) begin
      errors++;
      $display("FAIL bounce_released: level=%b required 00", pb.o_level);
    end
  endtask

  task automatic test_transit();
    // CLOSED x2, TRANSIT x3, CLOSED: FSM sees closed samples at edges 3,4,8,9.
    for (int n = 1; n <= 11; n++) begin
      if (n == 1) set_ch(0, PIN_CLOSED);
      if (n == 3) set_ch(0, PIN_TRANSIT);
      if (n == 6) set_ch(0, PIN_CLOSED);
      tick();
      checks++;
      if (pb.o_press !== ((n == 9) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL transit_press n=%0d: press=%b required %b", n, pb.o_press, (n == 9) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (pb.o_level !== 2'b01) begin
      errors++;
      $display("FAIL transit_level: level=%b required 01", pb.o_level);
    end
    set_ch(0, PIN_OPEN);
    wait_ticks(10);
  endtask

  task automatic test_fault();
    for (int n = 1; n <= 10; n++) begin
      if (n == 1) set_ch(0, PIN_INVALID);
      if (n == 7) set_ch(0, PIN_OPEN);
      tick();
      checks++;
      if (pb.o_fault !== ((n >= 6 && n <= 8) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL fault_flag n=%0d: fault=%b required %b", n, pb.o_fault, (n >= 6 && n <= 8) ? 2'b01 : 2'b00);
      end
      checks++;
      if ({pb.o_press, pb.o_release, pb.o_level} !== 6'b0) begin
        errors++;
        $display("FAIL fault_no_pulse n=%0d: press/release/level=%b required 0", n, {pb.o_press, pb.o_release, pb.o_level});
      end
    end
  endtask

  task automatic test_reset_held();
    set_ch(0, PIN_CLOSED);
    wait_ticks(7);
    checks++;
    if (pb.o_level !== 2'b01) begin
      errors++;
      $display("FAIL held_before_reset: level=%b required 01", pb.o_level);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({pb.o_level, pb.o_press, pb.o_release, pb.o_repeat, pb.o_fault} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0", {pb.o_level, pb.o_press, pb.o_release, pb.o_repeat, pb.o_fault});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (pb.o_release !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_release n=%0d: release=%b required 00", n, pb.o_release);
      end
      checks++;
      if (pb.o_press !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL reset_repress n=%0d: press=%b required %b", n, pb.o_press, (n == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  // ch0 still held from the previous test: release ch0 and press ch1 together,
  // then keep ch1 held to observe the auto-repeat train.
  task automatic test_back_to_back();
    logic [1:0] exp_rep;
    int         d;
    set_ch(0, PIN_OPEN);
    set_ch(1, PIN_CLOSED);
    for (int n = 1; n <= 30; n++) begin
      tick();
      d = n - 6;
      exp_rep = 2'b00;
`ifdef PB_AUTOREPEAT_EN
      if (d == 10 || d == 13 || d == 16 || d == 19 || d == 22) exp_rep = 2'b10;
`endif
      checks++;
      if (pb.o_press !== ((n == 6) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL b2b_press n=%0d: press=%b required %b", n, pb.o_press, (n == 6) ? 2'b10 : 2'b00);
      end
      checks++;
      if (pb.o_release !== ((n == 6) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL b2b_release n=%0d: release=%b required %b", n, pb.o_release, (n == 6) ? 2'b01 : 2'b00);
      end
      checks++;
      if (pb.o_level !== ((n >= 6) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b_level n=%0d: level=%b required %b", n, pb.o_level, (n >= 6) ? 2'b10 : 2'b01);
      end
      checks++;
      if (pb.o_repeat !== exp_rep) begin
        errors++;
        $display("FAIL repeat n=%0d: repeat=%b required %b", n, pb.o_repeat, exp_rep);
      end
    end
    set_ch(1, PIN_OPEN);
    wait_ticks(10);
    checks++;
    if ({pb.o_level, pb.o_repeat} !== 4'b0) begin
      errors++;
      $display("FAIL repeat_stops: level/repeat=%b required 0", {pb.o_level, pb.o_repeat});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    pb.i_nc = '0;
    pb.i_no = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_transit();
    test_fault();
    test_reset_held();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_debounce_multi.md
Name: pb_debounce_multi

Overview:
- N-channel pushbutton conditioner for the lab board's SPDT pushbuttons. Each button has an NC and an NO contact, both active-low.
- Per channel it provides:
  - break-before-make contact decode
  - 2-flop synchronizer
  - counter-based debounce
  - one-cycle press/release pulses, a stable level output and a stuck-contact fault flag
- Sits between the board pushbutton pins and user logic; supersedes the raw NC/NO handling in lab top levels.

Parameters:
- N_CH, 2, number of pushbutton channels (≥1)
- DEBOUNCE_CYCLES, 16, consecutive stable decoded samples required to change state (≥1)
- REPEAT_DELAY, 500, cycles held before first auto-repeat pulse (used only with PB_AUTOREPEAT_EN)
- REPEAT_RATE, 100, cycles between subsequent auto-repeat pulses (used only with PB_AUTOREPEAT_EN, ≥1)

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_nc  input  N_CH  NC contacts, active-low; 0 = button at rest position
- i_no  input  N_CH  NO contacts, active-low; 0 = button pushed
- o_level  output  N_CH  debounced state, 1 = pressed
- o_press  output  N_CH  one-cycle pulse on debounced press
- o_release  output  N_CH  one-cycle pulse on debounced release
- o_repeat  output  N_CH  auto-repeat pulses while held
- o_fault  output  N_CH  both contacts asserted for ≥ DEBOUNCE_CYCLES

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset:
  - All outputs go to 0.
  - Synchronizer flops reset to the decoded-OPEN value (nc=1, no=0 after inversion).
  - FSM goes to IDLE; counters go to 0.
  - Reset mid-press drops o_level immediately and emits no release pulse.
- Synchronizer:
  - Inputs are inverted to active-high, then pass through 2 flops per contact.
  - Decode uses the second flop.
- Contact decode per channel, on synced active-high (nc, no):
  - (1,0) = OPEN
  - (0,1) = CLOSED
  - (0,0) = TRANSIT
  - (1,1) = INVALID
- Counter width: CNT_W = $clog2(DEBOUNCE_CYCLES+1). Counters saturate and never wrap.
- FSM per channel: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE:
    - CLOSED → PRESS_WAIT, cnt=1.
    - Otherwise stay.
  - PRESS_WAIT:
    - CLOSED → cnt+1.
    - TRANSIT → cnt holds.
    - OPEN or INVALID → IDLE, cnt=0.
    - When cnt would reach DEBOUNCE_CYCLES → PRESSED; o_press=1 for that cycle; o_level=1.
  - PRESSED:
    - OPEN → RELEASE_WAIT, cnt=1.
    - Otherwise stay.
  - RELEASE_WAIT: mirror of PRESS_WAIT with OPEN/CLOSED swapped.
    - Completion → IDLE, o_release=1, o_level=0.
    - Abort on CLOSED/INVALID → PRESSED.
  - With DEBOUNCE_CYCLES=1, IDLE→PRESSED occurs directly and the WAIT state is skipped.
- Latency:
  - Input change captured at edge k gives o_press/o_release registered at edge k+1+DEBOUNCE_CYCLES.
  - That is DEBOUNCE_CYCLES+2 edges from the pin change.
- Fault:
  - A separate counter counts consecutive INVALID samples.
  - o_fault=1 once the count reaches DEBOUNCE_CYCLES.
  - o_fault=0 on the first non-INVALID sample.
  - The FSM does not advance on INVALID; its abort rules above apply.
- Channels are fully independent. Simultaneous press on one channel and release on another both pulse in the same cycle.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a hold counter runs.
  - o_repeat pulses one cycle at REPEAT_DELAY cycles after the o_press cycle, then every REPEAT_RATE cycles.
  - Leaving PRESSED (including entry to RELEASE_WAIT) clears the counter and the pulse sequence.
  - o_press and o_repeat never coincide.
- Undefined:
  - o_repeat is tied to 0; the port remains.
  - No hold counter is synthesized.

Decomposition:
- Package pb_pkg holds:
  - state typedef (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
  - contact typedef (OPEN, CLOSED, TRANSIT, INVALID)
  - decode function (nc, no) → contact
- Sub-module pb_channel:
  - contains synchronizer, FSM, debounce/fault/repeat counters for one channel
  - replicated N_CH times via generate
  - top level is wiring only

Test Plan (N_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
- Clean press on ch0:
  - Stimulus: i_nc[0]=1, i_no[0]=0 held.
  - Response: o_press[0]=1 for exactly one cycle, 6 edges after the change; o_level[0]=1 from then on; ch1 unaffected.
- Bounce:
  - Stimulus: ch0 toggles CLOSED/OPEN every 2 cycles ×5, then CLOSED steady.
  - Response: no pulse during toggling; single o_press 6 edges after the final change.
- Transit hold:
  - Stimulus: CLOSED 2 cycles, TRANSIT 3, CLOSED 2.
  - Response: o_press after a total of 4 CLOSED samples; no abort.
- Fault:
  - Stimulus: both contacts asserted for 6 cycles, then OPEN.
  - Response: o_fault[0]=1 after 4 synced INVALID samples; clears 1 cycle after OPEN is synced; no press/release pulses.
- Reset while held:
  - Stimulus: i_rst asserted while o_level[0]=1.
  - Response: all outputs 0 asynchronously; no o_release; after deassert with button still closed, new o_press after 6 edges.
- Auto-repeat (with PB_AUTOREPEAT_EN):
  - Stimulus: hold ch1 for 25 cycles after its press.
  - Response: o_repeat[1] at +10, +13, +16, +19, +22; undefined build gives o_repeat ≡ 0.
